// File: rtl/reg_file_pkg.sv
// Shared widths, register indices, exception codes and CP0 reset values
// for the architectural register file and its CP0 block.
package reg_file_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RF_ADDR_W  = 6;
  localparam int unsigned ROB_ADDR_W = 5;
  localparam int unsigned EXC_TYPE_W = 4;

  // GPR 0..31, then HI and LO; everything above LO is unmapped
  localparam int unsigned NUM_REGS = 34;
  localparam logic [RF_ADDR_W-1:0] RF_REG_HI = 6'd32;
  localparam logic [RF_ADDR_W-1:0] RF_REG_LO = 6'd33;

  typedef enum logic [EXC_TYPE_W-1:0] {
    EXC_NONE = 4'd0,
    EXC_ADEL = 4'd4,
    EXC_ADES = 4'd5,
    EXC_SYS  = 4'd8,
    EXC_BP   = 4'd9,
    EXC_RI   = 4'd10,
    EXC_OV   = 4'd12
  } exc_code_e;

  localparam logic [DATA_W-1:0] CP0_STATUS_RESET = 32'h0040_0000;
  localparam logic [DATA_W-1:0] CP0_CAUSE_RESET  = 32'h0000_0000;
  localparam logic [DATA_W-1:0] CP0_EPC_RESET    = 32'h0000_0000;
  localparam logic [DATA_W-1:0] CP0_EBASE_RESET  = 32'h8000_0000;

  function automatic logic is_addr_error(input logic [EXC_TYPE_W-1:0] code);
    return (exc_code_e'(code) == EXC_ADEL) || (exc_code_e'(code) == EXC_ADES);
  endfunction

endpackage

// File: rtl/reg_file_cp0_regs.sv
// Minimal CP0: Status/Cause/EPC/EBase, updated only by committed exceptions
// and by the free-running hardware interrupt sample in Cause.
module cp0_regs
  import reg_file_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            hard_int_i,
  input  logic [DATA_W-1:0]     badvaddr_data_i,
  input  logic [EXC_TYPE_W-1:0] exception_type_i,
  input  logic                  is_delayslot_i,
  input  logic [DATA_W-1:0]     current_pc_i,
  output logic [DATA_W-1:0]     status_o,
  output logic [DATA_W-1:0]     cause_o,
  output logic [DATA_W-1:0]     epc_o,
  output logic [DATA_W-1:0]     ebase_o
);

  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [DATA_W-1:0] badvaddr_q, badvaddr_d;

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    cause_d[15:10] = hard_int_i;

    if (exception_type_i != '0) begin
      status_d[1]   = 1'b1;
      cause_d[6:2]  = {1'b0, exception_type_i};
      cause_d[31]   = is_delayslot_i;
      epc_d         = is_delayslot_i ? (current_pc_i - 32'd4) : current_pc_i;
      if (is_addr_error(exception_type_i)) begin
        badvaddr_d = badvaddr_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= CP0_STATUS_RESET;
      cause_q    <= CP0_CAUSE_RESET;
      epc_q      <= CP0_EPC_RESET;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign ebase_o  = CP0_EBASE_RESET;

endmodule

// File: rtl/reg_file.sv
// Architectural GPR/HI/LO file with ROB rename tags; dispatch reads return
// either a committed value or the producing ROB id.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_W,
  parameter int unsigned RF_ADDR_WIDTH  = RF_ADDR_W,
  parameter int unsigned ROB_ADDR_WIDTH = ROB_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [RF_ADDR_WIDTH-1:0]  write_addr,
  input  logic [ROB_ADDR_WIDTH-1:0] write_ref_id,
  input  logic                      write_lo_en,
  input  logic [ROB_ADDR_WIDTH-1:0] write_lo_ref_id,
  input  logic                      commit_restore,
  input  logic                      commit_add,
  input  logic                      commit_en,
  input  logic [RF_ADDR_WIDTH-1:0]  commit_addr,
  input  logic [DATA_WIDTH-1:0]     commit_data,
  input  logic                      commit_lo_en,
  input  logic [DATA_WIDTH-1:0]     commit_lo_data,
  input  logic                      read_en_1,
  input  logic [RF_ADDR_WIDTH-1:0]  read_addr_1,
  output logic                      read_is_ref_1,
  output logic [DATA_WIDTH-1:0]     read_data_1,
  input  logic                      read_en_2,
  input  logic [RF_ADDR_WIDTH-1:0]  read_addr_2,
  output logic                      read_is_ref_2,
  output logic [DATA_WIDTH-1:0]     read_data_2,
  input  logic [5:0]                hard_int,
  input  logic [DATA_WIDTH-1:0]     badvaddr_data,
  input  logic [EXC_TYPE_W-1:0]     exception_type,
  input  logic                      is_delayslot,
  input  logic [DATA_WIDTH-1:0]     current_pc,
  output logic [DATA_WIDTH-1:0]     cp0_status,
  output logic [DATA_WIDTH-1:0]     cp0_cause,
  output logic [DATA_WIDTH-1:0]     cp0_epc,
  output logic [DATA_WIDTH-1:0]     cp0_ebase
);

  logic [DATA_WIDTH-1:0]     value_q  [NUM_REGS];
  logic [DATA_WIDTH-1:0]     value_d  [NUM_REGS];
  logic                      is_ref_q [NUM_REGS];
  logic                      is_ref_d [NUM_REGS];
  logic [ROB_ADDR_WIDTH-1:0] ref_id_q [NUM_REGS];
  logic [ROB_ADDR_WIDTH-1:0] ref_id_d [NUM_REGS];

  logic commit_hit, write_hit;

  // Register 0 and the unmapped window 34..63 never take writes or tags
  assign commit_hit = commit_en && (commit_addr != '0) && (commit_addr <= RF_REG_LO);
  assign write_hit  = write_en  && (write_addr  != '0) && (write_addr  <= RF_REG_LO);

  // Ordering: commit value/clear, then LO commit, then dispatch tag, then flush
  always_comb begin
    value_d  = value_q;
    is_ref_d = is_ref_q;
    ref_id_d = ref_id_q;

    if (commit_hit) begin
      value_d[commit_addr] = commit_data;
      if (commit_add) begin
        is_ref_d[commit_addr] = 1'b0;
      end
    end
    if (commit_lo_en) begin
      value_d[RF_REG_LO] = commit_lo_data;
    end

    if (write_hit) begin
      is_ref_d[write_addr] = 1'b1;
      ref_id_d[write_addr] = write_ref_id;
    end
    if (write_lo_en) begin
      is_ref_d[RF_REG_LO] = 1'b1;
      ref_id_d[RF_REG_LO] = write_lo_ref_id;
    end

    if (commit_restore) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        is_ref_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        value_q[i]  <= '0;
        is_ref_q[i] <= 1'b0;
        ref_id_q[i] <= '0;
      end
    end else begin
      value_q  <= value_d;
      is_ref_q <= is_ref_d;
      ref_id_q <= ref_id_d;
    end
  end

  always_comb begin
    read_is_ref_1 = 1'b0;
    read_data_1   = '0;
    if (read_en_1 && (read_addr_1 <= RF_REG_LO)) begin
      if (is_ref_q[read_addr_1]) begin
        read_is_ref_1 = 1'b1;
        read_data_1   = {{(DATA_WIDTH-ROB_ADDR_WIDTH){1'b0}}, ref_id_q[read_addr_1]};
      end else begin
        read_data_1   = value_q[read_addr_1];
      end
    end
  end

  always_comb begin
    read_is_ref_2 = 1'b0;
    read_data_2   = '0;
    if (read_en_2 && (read_addr_2 <= RF_REG_LO)) begin
      if (is_ref_q[read_addr_2]) begin
        read_is_ref_2 = 1'b1;
        read_data_2   = {{(DATA_WIDTH-ROB_ADDR_WIDTH){1'b0}}, ref_id_q[read_addr_2]};
      end else begin
        read_data_2   = value_q[read_addr_2];
      end
    end
  end

  cp0_regs u_cp0 (
    .clk              (clk),
    .rst              (rst),
    .hard_int_i       (hard_int),
    .badvaddr_data_i  (badvaddr_data),
    .exception_type_i (exception_type),
    .is_delayslot_i   (is_delayslot),
    .current_pc_i     (current_pc),
    .status_o         (cp0_status),
    .cause_o          (cp0_cause),
    .epc_o            (cp0_epc),
    .ebase_o          (cp0_ebase)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected observations are queued when each
// stimulus step is driven and drained against the DUT after the edge.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en, write_lo_en, commit_restore, commit_add, commit_en, commit_lo_en;
  logic [5:0]  write_addr, commit_addr, read_addr_1, read_addr_2;
  logic [4:0]  write_ref_id, write_lo_ref_id;
  logic [31:0] commit_data, commit_lo_data, badvaddr_data, current_pc;
  logic        read_en_1, read_en_2, read_is_ref_1, read_is_ref_2, is_delayslot;
  logic [31:0] read_data_1, read_data_2;
  logic [5:0]  hard_int;
  logic [3:0]  exception_type;
  logic [31:0] cp0_status, cp0_cause, cp0_epc, cp0_ebase;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .write_ref_id(write_ref_id),
    .write_lo_en(write_lo_en), .write_lo_ref_id(write_lo_ref_id),
    .commit_restore(commit_restore), .commit_add(commit_add), .commit_en(commit_en),
    .commit_addr(commit_addr), .commit_data(commit_data),
    .commit_lo_en(commit_lo_en), .commit_lo_data(commit_lo_data),
    .read_en_1(read_en_1), .read_addr_1(read_addr_1),
    .read_is_ref_1(read_is_ref_1), .read_data_1(read_data_1),
    .read_en_2(read_en_2), .read_addr_2(read_addr_2),
    .read_is_ref_2(read_is_ref_2), .read_data_2(read_data_2),
    .hard_int(hard_int), .badvaddr_data(badvaddr_data),
    .exception_type(exception_type), .is_delayslot(is_delayslot),
    .current_pc(current_pc),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc), .cp0_ebase(cp0_ebase)
  );

  // kind: 0/1 = read port 1/2 (with en), 2 = read port 1 disabled,
  //       3 status, 4 cause, 5 epc, 6 ebase
  typedef struct {
    string       tag;
    int          kind;
    logic [5:0]  addr;
    logic        is_ref;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input int kind, input logic [5:0] addr,
                      input logic is_ref, input logic [31:0] data);
    exp_t e;
    e.tag = tag; e.kind = kind; e.addr = addr; e.is_ref = is_ref; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    write_en = 0; write_addr = 0; write_ref_id = 0;
    write_lo_en = 0; write_lo_ref_id = 0;
    commit_restore = 0; commit_add = 0; commit_en = 0; commit_addr = 0;
    commit_data = 0; commit_lo_en = 0; commit_lo_data = 0;
    exception_type = 0; is_delayslot = 0; current_pc = 0; badvaddr_data = 0;
    read_en_1 = 0; read_en_2 = 0; read_addr_1 = 0; read_addr_2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic drain();
    exp_t        e;
    logic [32:0] obs, req;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      read_en_1 = (e.kind == 0); read_addr_1 = e.addr;
      read_en_2 = (e.kind == 1); read_addr_2 = e.addr;
      #1;
      case (e.kind)
        0:       obs = {read_is_ref_1, read_data_1};
        1:       obs = {read_is_ref_2, read_data_2};
        2:       obs = {read_is_ref_1, read_data_1};
        3:       obs = {1'b0, cp0_status};
        4:       obs = {1'b0, cp0_cause};
        5:       obs = {1'b0, cp0_epc};
        default: obs = {1'b0, cp0_ebase};
      endcase
      req = {e.is_ref, e.data};
      n_cmp++;
      assert (obs === req) else begin
        n_fail++;
        $error("FAIL %s: observed ref=%0b data=%h, expected ref=%0b data=%h",
               e.tag, obs[32], obs[31:0], req[32], req[31:0]);
      end
      read_en_1 = 0; read_en_2 = 0;
    end
  endtask

  initial begin
    idle_inputs();
    hard_int = 6'h00;
    rst = 1'b1;
    #12;
    rst = 1'b0;

    push("reset_r1", 0, 6'd1, 0, 32'h0);
    push("reset_hi", 1, 6'd32, 0, 32'h0);
    push("reset_status", 3, 0, 0, 32'h0040_0000);
    push("reset_cause", 4, 0, 0, 32'h0);
    push("reset_epc", 5, 0, 0, 32'h0);
    push("reset_ebase", 6, 0, 0, 32'h8000_0000);
    drain();

    @(negedge clk);
    commit_en = 1; commit_addr = 6'd1; commit_data = 32'h1234_5678;
    push("commit_r1", 0, 6'd1, 0, 32'h1234_5678);
    push("untouched_r2", 1, 6'd2, 0, 32'h0);
    tick(); drain();

    @(negedge clk);
    write_en = 1; write_addr = 6'd1; write_ref_id = 5'h0a;
    push("tag_r1", 0, 6'd1, 1, 32'h0000_000a);
    push("r1_disabled", 2, 6'd1, 0, 32'h0);
    tick(); drain();

    @(negedge clk);
    write_en = 1; write_addr = 6'd2; write_ref_id = 5'h0f;
    commit_en = 1; commit_addr = 6'd2; commit_data = 32'habcd_ef00; commit_add = 1;
    push("write_beats_commit_add", 1, 6'd2, 1, 32'h0000_000f);
    tick(); drain();

    @(negedge clk);
    commit_restore = 1;
    push("restore_r1", 0, 6'd1, 0, 32'h1234_5678);
    push("restore_r2", 1, 6'd2, 0, 32'habcd_ef00);
    tick(); drain();

    @(negedge clk);
    commit_en = 1; commit_add = 1; commit_addr = 6'd32; commit_data = 32'h1020_3040;
    commit_lo_en = 1; commit_lo_data = 32'h1;
    push("commit_hi", 0, 6'd32, 0, 32'h1020_3040);
    push("commit_lo", 1, 6'd33, 0, 32'h1);
    tick(); drain();

    // reg 0 and unmapped addresses ignore writes and commits
    @(negedge clk);
    write_en = 1; write_addr = 6'd0; write_ref_id = 5'h11;
    commit_en = 1; commit_addr = 6'd0; commit_data = 32'hdead_beef;
    push("r0_hardwired", 0, 6'd0, 0, 32'h0);
    tick(); drain();
    @(negedge clk);
    write_en = 1; write_addr = 6'd40; write_ref_id = 5'h12;
    commit_en = 1; commit_addr = 6'd40; commit_data = 32'hdead_beef;
    push("unmapped_40", 1, 6'd40, 0, 32'h0);
    tick(); drain();

    // commit_lo_data wins over commit_data aimed at LO; LO tag via write_lo
    @(negedge clk);
    commit_en = 1; commit_addr = 6'd33; commit_data = 32'h5555_5555;
    commit_lo_en = 1; commit_lo_data = 32'haaaa_aaaa;
    write_lo_en = 1; write_lo_ref_id = 5'h1f;
    write_en = 1; write_addr = 6'd32; write_ref_id = 5'h03;
    push("lo_tag", 1, 6'd33, 1, 32'h0000_001f);
    push("hi_tag", 0, 6'd32, 1, 32'h0000_0003);
    tick(); drain();

    // commit without add keeps the tag; with add clears it
    @(negedge clk);
    commit_en = 1; commit_addr = 6'd32; commit_data = 32'h7777_0000;
    push("commit_noadd_keeps", 0, 6'd32, 1, 32'h0000_0003);
    tick(); drain();
    @(negedge clk);
    commit_en = 1; commit_add = 1; commit_addr = 6'd32; commit_data = 32'h7777_0001;
    push("commit_add_clears", 0, 6'd32, 0, 32'h7777_0001);
    tick(); drain();

    // restore overrides a same-cycle write tag
    @(negedge clk);
    commit_restore = 1;
    write_en = 1; write_addr = 6'd5; write_ref_id = 5'h09;
    push("restore_beats_write", 1, 6'd5, 0, 32'h0);
    push("lo_after_restore", 0, 6'd33, 0, 32'haaaa_aaaa);
    tick(); drain();

    @(negedge clk);
    hard_int = 6'h01;
    exception_type = 4'd4; is_delayslot = 1; current_pc = 32'hbfc0_0010;
    badvaddr_data = 32'h0000_0003;
    push("exc_status", 3, 0, 0, 32'h0040_0002);
    push("exc_cause", 4, 0, 0, 32'h8000_0410);
    push("exc_epc_ds", 5, 0, 0, 32'hbfc0_000c);
    push("exc_ebase", 6, 0, 0, 32'h8000_0000);
    tick(); drain();

    @(negedge clk);
    hard_int = 6'h3f;
    exception_type = 4'd8; is_delayslot = 0; current_pc = 32'h0000_0100;
    push("exc2_cause", 4, 0, 0, 32'h0000_fc20);
    push("exc2_epc", 5, 0, 0, 32'h0000_0100);
    push("exc2_status", 3, 0, 0, 32'h0040_0002);
    tick(); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags for the out-of-order MIPS core. Holds 32 GPRs plus HI/LO.
- Each register carries a committed value and a "pending" tag pointing at the ROB entry that will produce its next value.
- Dispatch reads operands as either a value or a ROB ref, and tags destinations. ROB commit writes committed values and can flush all tags.
- Also hosts a minimal CP0 (Status/Cause/EPC/EBase) updated on committed exceptions.

Parameters:
- DATA_WIDTH, 32, data word width.
- RF_ADDR_WIDTH, 6, register address width: 0–31 GPR, 32 = RF_REG_HI, 33 = RF_REG_LO, 34–63 unused.
- ROB_ADDR_WIDTH, 5, ROB entry id width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- write_en  in  1  tag destination register at dispatch.
- write_addr  in  RF_ADDR_WIDTH  destination register.
- write_ref_id  in  ROB_ADDR_WIDTH  producing ROB id.
- write_lo_en  in  1  also tag LO (mult/div).
- write_lo_ref_id  in  ROB_ADDR_WIDTH  ROB id for LO.
- commit_restore  in  1  flush: clear every pending tag.
- commit_add  in  1  committing entry is the youngest writer of commit_addr; clear its tag.
- commit_en  in  1  commit commit_data to commit_addr.
- commit_addr  in  RF_ADDR_WIDTH  committed register.
- commit_data  in  DATA_WIDTH  committed value.
- commit_lo_en  in  1  commit commit_lo_data to LO.
- commit_lo_data  in  DATA_WIDTH  LO value.
- read_en_1/2  in  1  read port enables.
- read_addr_1/2  in  RF_ADDR_WIDTH  read addresses.
- read_is_ref_1/2  out  1  operand is a pending ROB ref.
- read_data_1/2  out  DATA_WIDTH  value, or zero-extended ROB id when is_ref.
- hard_int  in  6  hardware interrupt lines.
- badvaddr_data  in  DATA_WIDTH  faulting address.
- exception_type  in  EXC_TYPE_WIDTH (4)  committed exception code; 0 = none.
- is_delayslot  in  1  excepting instruction is in a delay slot.
- current_pc  in  DATA_WIDTH  PC of excepting instruction.
- cp0_status, cp0_cause, cp0_epc, cp0_ebase  out  DATA_WIDTH  CP0 register values.

Behaviour:
- State per register: value, is_ref, ref_id. Register 0 is hardwired: value 0, never tagged; writes and commits to it are ignored. Addresses 34–63 read 0 and are never tagged.
- Reset: all values 0, all is_ref 0, ref_id 0. cp0_status = 32'h0040_0000 (BEV), cp0_cause = 0, cp0_epc = 0, cp0_ebase = 32'h8000_0000.
- Reads are combinational from current registered state; there is no same-cycle bypass of write or commit. read_en = 0 gives data 0 and is_ref 0.
- Commit (posedge): commit_en writes value[commit_addr] = commit_data. If commit_add is also set, clear is_ref[commit_addr]. commit_lo_en writes LO value independently; if commit_addr = LO in the same cycle, commit_lo_data wins.
- Write (posedge): write_en sets is_ref = 1 and ref_id = write_ref_id. write_lo_en does the same for LO.
- Same register written and committed in one cycle: the value updates, and the tag is set from the write (the write takes priority over the commit_add clear).
- commit_restore: clears every is_ref at that edge, after applying any same-cycle commit. It also overrides a same-cycle write tag.
- CP0:
  - cause[15:10] samples hard_int every cycle.
  - When exception_type != 0: status[1] (EXL) = 1, cause[6:2] = exception_type, cause[31] = is_delayslot, epc = is_delayslot ? current_pc − 4 : current_pc.
  - BadVAddr is captured internally for address-error codes but is not output.
  - No MTC0 path; EBase stays constant after reset.

Decomposition:
- Shared package: DATA width, RF_ADDR/ROB_ADDR widths, RF_REG_HI/RF_REG_LO, exception codes, and CP0 reset constants.
- One natural sub-module, cp0_regs, holding Status/Cause/EPC/EBase/BadVAddr; the top level keeps the GPR/HI/LO array and tag logic.

Test Plan:
- Reset, then commit_en with addr 1, data 32'h12345678 → next cycle read 1 gives is_ref 0 and data 12345678; read 2 gives 0. CP0 outputs show their reset values.
- write_en with addr 1, ref 5'h0a → next cycle read 1 gives is_ref 1 and data 32'h0000000a.
- write_en with addr 2, ref 5'h0f, plus commit_en with addr 2, data 32'habcdef00 in the same cycle → read 2 gives is_ref 1 and data 0000000f. The committed value abcdef00 must appear after the restore below.
- commit_restore → read 1 gives 12345678 and read 2 gives abcdef00, both with is_ref 0.
- commit_en + commit_add with addr HI, data 32'h10203040, and commit_lo_en with data 1 → read HI gives 10203040 and read LO gives 1, both with is_ref 0.
- exception_type = 4, is_delayslot = 1, current_pc = 32'hbfc00010 → EXL set, cause[6:2] = 4, BD = 1, epc = bfc0000c; hard_int = 6'h01 appears in cause[10].
